exu_muldiv_ctrl: RTL

//  Multi-cycle sequencer for RV64M ops issued to the execute stage. Takes the already-forwarded

---
 rtl/exu_muldiv_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/exu_muldiv_ctrl.sv
// rtl/exu_muldiv_ctrl.sv - iterative RV64M multiply/divide sequencer for the execute stage
module exu_muldiv_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush_nop,
    input  logic            md_start,
    input  logic [2:0]      md_opcode,
    input  logic            md_halfop,
    input  logic [XLEN-1:0] md_src1,
    input  logic [XLEN-1:0] md_src2,
    input  logic [4:0]      md_rd_in,
    output logic            md_stall,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result,
    output logic [4:0]      md_rd
);

    localparam int DW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              w_q, w_d, neg_q, neg_d, rneg_q, rneg_d;
    logic [DW-1:0]     acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    logic              w_in, s1_sgn, s2_sgn, a_neg, b_neg, div_zero, div_ovf, start_ok;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, spec_val;
    logic [XLEN:0]     rem_sh, diff;
    logic [DW-1:0]     prod;
    logic [XLEN-1:0]   quot, rem, fin_raw, fin;
    logic              load_res, w_c;

    // Operands are reduced to magnitudes so both datapaths run unsigned.
    assign w_in     = md_halfop & ((md_opcode == 3'd0) | md_opcode[2]);
    assign s1_sgn   = (md_opcode == 3'd1) | (md_opcode == 3'd2) | (md_opcode == 3'd4) | (md_opcode == 3'd6);
    assign s2_sgn   = (md_opcode == 3'd1) | (md_opcode == 3'd4) | (md_opcode == 3'd6);
    assign a_ext    = w_in ? {{(XLEN-32){s1_sgn & md_src1[31]}}, md_src1[31:0]} : md_src1;
    assign b_ext    = w_in ? {{(XLEN-32){s2_sgn & md_src2[31]}}, md_src2[31:0]} : md_src2;
    assign a_neg    = s1_sgn & a_ext[XLEN-1];
    assign b_neg    = s2_sgn & b_ext[XLEN-1];
    assign a_mag    = a_neg ? -a_ext : a_ext;
    assign b_mag    = b_neg ? -b_ext : b_ext;
    assign min_val  = w_in ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = md_opcode[2] & (b_ext == '0);
    assign div_ovf  = md_opcode[2] & ~md_opcode[0] & (a_ext == min_val) & (&b_ext);
    assign spec_val = div_zero ? (md_opcode[1] ? a_ext : '1) : (md_opcode[1] ? '0 : a_ext);
    assign start_ok = md_start & ~flush_nop;

    assign rem_sh   = acc_q[DW-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, mcand_q[XLEN-1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        w_d      = w_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rd_d     = rd_q;
        load_res = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    op_d   = md_opcode;
                    w_d    = w_in;
                    rd_d   = md_rd_in;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = w_in ? CNT_W'(32) : CNT_W'(XLEN);
                    if (div_zero | div_ovf) begin
                        acc_d    = {{XLEN{1'b0}}, spec_val};
                        load_res = 1'b1;
                        state_d  = S_DONE;
                    end else if (md_opcode[2]) begin
                        // W dividends sit in the top half so 32 steps consume them.
                        acc_d   = w_in ? {{XLEN{1'b0}}, a_mag[31:0], {(XLEN-32){1'b0}}}
                                       : {{XLEN{1'b0}}, a_mag};
                        mcand_d = {{XLEN{1'b0}}, b_mag};
                        state_d = S_BUSY;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = {{XLEN{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[2]) begin
                    if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    load_res = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_nop) begin
            state_d  = S_IDLE;
            load_res = 1'b0;
        end
    end

    // Final sign fix-up and half/quotient/remainder selection from the next accumulator.
    always_comb begin
        prod    = neg_q ? -acc_d : acc_d;
        quot    = acc_d[XLEN-1:0];
        rem     = acc_d[DW-1:XLEN];
        w_c     = (state_q == S_IDLE) ? w_in : w_q;
        fin_raw = acc_d[XLEN-1:0];
        if (state_q != S_IDLE) begin
            if (!op_q[2])    fin_raw = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[DW-1:XLEN];
            else if (op_q[1]) fin_raw = rneg_q ? -rem : rem;
            else             fin_raw = neg_q ? -quot : quot;
        end
        fin      = w_c ? {{(XLEN-32){fin_raw[31]}}, fin_raw[31:0]} : fin_raw;
        valid_d  = load_res;
        result_d = load_res ? fin : result_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            w_q      <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            w_q      <= w_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign md_stall  = (state_q == S_BUSY) | ((state_q == S_IDLE) & start_ok);
    assign md_valid  = valid_q;
    assign md_result = result_q;
    assign md_rd     = rd_q;

endmodule
